ascii_guess_parser: RTL

//  Receive-side companion to the ASCII messenger in the random number game. Pops bytes

---
 rtl/game_pkg.sv | 27 ++
 rtl/ascii_digit_decode.sv | 21 ++
 rtl/ascii_guess_parser.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the random number game: ASCII constants, parser error codes
// and the parser state encoding.
// Latency: n/a (declarations only). Backpressure: n/a.
// Used by the guess parser, the game FSM and the message ROM indexing.
package game_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BADCHAR  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_RANGE    = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_REPORT  = 2'd3
  } parse_state_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Classifies one received byte: decimal digit (with its value), line terminator, space.
// Latency: purely combinational. Backpressure: none.
// Ports: i_byte in; o_is_digit, o_digit[3:0], o_is_term (CR/LF), o_is_space out.
module ascii_digit_decode
  import game_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_digit,
  output logic [3:0] o_digit,
  output logic       o_is_term,
  output logic       o_is_space
);

  assign o_is_digit = (i_byte >= ASCII_ZERO) && (i_byte <= ASCII_NINE);
  // '0'..'9' are 0x30..0x39, so the low nibble is the digit value; only
  // meaningful while o_is_digit is set.
  assign o_digit    = i_byte[3:0];
  assign o_is_term  = (i_byte == ASCII_CR) || (i_byte == ASCII_LF);
  assign o_is_space = (i_byte == ASCII_SPACE);

endmodule

// File: rtl/ascii_guess_parser.sv
// Pops bytes from the UART RX FIFO and parses a CR/LF terminated decimal guess.
// Latency: terminator popped in cycle t -> guess_valid or err pulse in cycle t+1.
// Backpressure: pops only while rx_empty==0, one byte per cycle, no pop in the report cycle.
// Ports: clk, reset (sync, active high), enable, rx_data[7:0], rx_empty in;
//        rd_uart, guess[VAL_W-1:0], guess_valid, err, err_code[1:0] out.
module ascii_guess_parser
  import game_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int VAL_W      = 10,
  parameter int MAX_VAL    = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       rx_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  output logic [VAL_W-1:0] guess,
  output logic             guess_valid,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  parse_state_t     r_state;
  parse_state_t     w_next_state;
  logic [VAL_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  err_code_t        r_code;
  logic [VAL_W-1:0] r_guess;

  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic             w_is_term;
  logic             w_is_space;
  logic             w_pop;
  logic             w_cnt_full;
  logic             w_over;
  logic             w_report;
  logic             w_take;

  ascii_digit_decode u_decode (
    .i_byte     (rx_data),
    .o_is_digit (w_is_digit),
    .o_digit    (w_digit),
    .o_is_term  (w_is_term),
    .o_is_space (w_is_space)
  );

  assign w_pop      = rd_uart;
  assign w_cnt_full = (r_cnt == CNT_W'(MAX_DIGITS));
  assign w_over     = (r_acc > VAL_W'(MAX_VAL));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_is_digit)                    w_next_state = ST_ACCUM;
            else if (!w_is_term && !w_is_space) w_next_state = ST_DISCARD;
          end
        end
        ST_ACCUM: begin
          if (w_pop) begin
            if (w_is_term)                     w_next_state = ST_REPORT;
            else if (!w_is_digit || w_cnt_full) w_next_state = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (w_pop && w_is_term) w_next_state = ST_REPORT;
        end
        ST_REPORT: w_next_state = ST_IDLE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs. Pulses are gated by enable/reset so a report cycle that coincides
  // with either of them is silently abandoned. guess shows the new value in the
  // same cycle as guess_valid, then holds it from r_guess.
  always_comb begin
    rd_uart     = !reset && !rx_empty && (r_state != ST_REPORT);
    w_report    = !reset && enable && (r_state == ST_REPORT);
    w_take      = w_report && (r_code == ERR_NONE) && !w_over;
    guess_valid = w_take;
    err         = w_report && !w_take;
    err_code    = ERR_NONE;
    if (err) err_code = (r_code != ERR_NONE) ? r_code : ERR_RANGE;
    guess       = w_take ? r_acc : r_guess;
  end

  // Datapath: accumulator, digit count, sticky first error, held guess.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_code  <= ERR_NONE;
      r_guess <= '0;
    end else begin
      if (w_take) r_guess <= r_acc;
      if (!enable || (r_state == ST_REPORT)) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_code <= ERR_NONE;
      end else if (w_pop) begin
        case (r_state)
          ST_IDLE: begin
            if (w_is_digit) begin
              r_acc <= {{(VAL_W-4){1'b0}}, w_digit};
              r_cnt <= CNT_W'(1);
            end else if (!w_is_term && !w_is_space) begin
              r_code <= ERR_BADCHAR;
            end
          end
          ST_ACCUM: begin
            if (w_is_digit) begin
              if (w_cnt_full) begin
                r_code <= ERR_OVERFLOW;
              end else begin
                // acc*10 + d; the digit cap keeps this inside VAL_W bits
                r_acc <= (r_acc << 3) + (r_acc << 1) + {{(VAL_W-4){1'b0}}, w_digit};
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else if (!w_is_term) begin
              r_code <= ERR_BADCHAR;
            end
          end
          default: ; // DISCARD keeps the first error code
        endcase
      end
    end
  end

endmodule
